quad_dec: RTL
=============

# quad_dec

Quadrature decoder: the receiving end of the A/B signals produced by the encoder imitators and the physical encoder inputs. Synchronises and glitch-filters A, B and Z and decodes Gray transitions in x4 mode into a signed position counter, a step/dir pulse pair and an illegal-transition flag. Also captures the position on the index (Z) edge and on the global snapshot strobe. Intended to sit per channel behind enc_bus, replacing ad-hoc decoding there.

## Interface
- CNT_WIDTH, 32: position counter width; two's complement, wraps.
- FILT_LEN, 4: consecutive stable cycles required before a filtered level changes; legal range >= 1.
- clk  in  1  system clock
- sclr  in  1  synchronous active-high reset
- A, B, Z  in  1 each  raw encoder inputs, asynchronous to clk
- clr  in  1  clears count, err, z_flag; does not restart ARM
- snapshot  in  1  global snapshot strobe, one-cycle pulse
- count  out  CNT_WIDTH  live position
- count_snap  out  CNT_WIDTH  position captured by snapshot
- index_pos  out  CNT_WIDTH  position captured at Z rising edge
- step  out  1  one-cycle pulse per decoded legal transition
- dir  out  1  direction of last legal transition: 1 = forward, 0 = reverse
- changed  out  1  sticky; a step occurred since the last snapshot
- err  out  1  sticky; illegal transition seen (A and B changed together)
- z_flag  out  1  sticky; an index edge has been captured
- Reset: all outputs 0. Reset is synchronous active-high on sclr, single clock clk; no other reset exists.

## Operation
- Sync: two flops per input (s1, s2); all logic below uses s2.
- Filter, per channel (A, B, Z): counter fcnt, filtered level f.
  - If s2 == f: fcnt <= 0.
  - Else if fcnt == FILT_LEN-1: f <= s2, fcnt <= 0.
  - Else: fcnt++.
  - A pulse shorter than FILT_LEN cycles at s2 never reaches f.
- FSM:
  - ARM, entered on sclr: loads fA/fB/fZ and previous copies pA/pB/pZ directly from s2 each cycle, no decoding. After 3 cycles in ARM -> RUN. This gives no spurious count when inputs are high at reset.
  - RUN: every cycle p <= f; decode {pA,pB} -> {fA,fB}.
- Decode, forward sequence 00->01->11->10->00:
  - Forward step: count+1, dir<=1, step<=1.
  - Reverse step: count-1, dir<=0, step<=1.
  - No change: step<=0.
  - Both bits changed: err<=1, count and dir unchanged, step<=0.
- Arithmetic: count is modulo 2^CNT_WIDTH; 0 - 1 = all ones, max + 1 = 0; no saturation.
- Index: pZ==0 && fZ==1 in RUN -> index_pos <= count value after this cycle's update, z_flag<=1.
- Snapshot: count_snap <= count register value before this cycle's update; changed <= 0.
- changed: set on any step. Snapshot and step in the same cycle -> changed = 1, because the step is not included in the captured value.
- clr: count <= 0, err <= 0, z_flag <= 0. clr wins over a same-cycle step or illegal transition (count = 0, err = 0). step/dir still reflect the decode. clr with Z edge -> index_pos = 0, z_flag = 0.
- sclr mid-operation: everything returns to reset values next cycle and the FSM re-enters ARM. An in-flight filter count is discarded.

## Timing
- Input level change first sampled at edge 0 -> s2 at edge 1 -> f updates at edge FILT_LEN+1 -> count/step/dir registered at edge FILT_LEN+2.
- Latency is therefore FILT_LEN+2 cycles; 6 for the default.
- step is high exactly one cycle per legal transition.
- Maximum decodable edge rate: one transition per FILT_LEN+1 cycles per channel.
- Snapshot capture is registered: count_snap is valid the cycle after the snapshot strobe.
- After sclr deasserts, decoding starts on the 4th edge; transitions occurring earlier are absorbed as initial state.

## Test plan
- Forward counting: reset with A=B=0, wait 10 cycles, then drive 10 full forward Gray cycles at 20 cycles per state -> count=40, dir=1, 40 step pulses, err=0. Then 3 reverse cycles -> count=28, dir=0.
- Wrap-around and latency: from count=0, one reverse transition -> count=0xFFFFFFFF. Measure A edge to step -> 6 cycles.
- Glitch and illegal transitions: a 3-cycle pulse on A (FILT_LEN=4) -> no step, count unchanged. Toggle A and B simultaneously -> err=1, count unchanged. clr -> err=0, count=0.
- Index capture: at count=17, raise Z for 10 cycles -> index_pos=17, z_flag=1. A 2-cycle Z glitch -> no capture.
- Snapshot collisions: snapshot while a step lands at count 5->6 -> count_snap=5, changed=1. Snapshot alone later -> count_snap=6, changed=0. clr with a forward step in the same cycle -> count=0.
- Reset behaviour: hold A=B=1 through sclr -> count stays 0 after ARM. Assert sclr mid-sequence at count=9 -> all outputs 0 next cycle, and counting resumes correctly after ARM.

Source files
------------

// File: rtl/quad_dec.sv
// rtl/quad_dec.sv - x4 quadrature decoder with input filtering, index and snapshot capture
// Sync + glitch filter on A/B/Z, Gray decode into a wrapping signed position counter.
module quad_dec #(
  parameter int CNT_WIDTH = 32,
  parameter int FILT_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 A,
  input  logic                 B,
  input  logic                 Z,
  input  logic                 clr,
  input  logic                 snapshot,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] count_snap,
  output logic [CNT_WIDTH-1:0] index_pos,
  output logic                 step,
  output logic                 dir,
  output logic                 changed,
  output logic                 err,
  output logic                 z_flag
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic {ST_ARM, ST_RUN} state_t;

  state_t               state, state_nxt;
  logic [1:0]           arm_cnt, arm_cnt_nxt;
  logic [2:0]           s1, s2, f, p;   // bit 0 = A, 1 = B, 2 = Z
  logic [FW-1:0]        fcnt [3];
  logic                 run, a_chg, b_chg, mv, illegal, fwd;
  logic                 do_step, do_err, z_rise;
  logic [CNT_WIDTH-1:0] count_nxt;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state   <= ST_ARM;
      arm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = '0;
    case (state)
      ST_ARM: begin
        arm_cnt_nxt = arm_cnt + 2'd1;
        if (arm_cnt == 2'd2) state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_ARM;
    endcase
  end

  // Forward order is 00->01->11->10; for a single-bit change, old A xor new B marks forward.
  always_comb begin
    run       = (state == ST_RUN);
    a_chg     = p[0] ^ f[0];
    b_chg     = p[1] ^ f[1];
    mv        = a_chg ^ b_chg;
    illegal   = a_chg & b_chg;
    fwd       = p[0] ^ f[1];
    do_step   = run & mv;
    do_err    = run & illegal;
    z_rise    = run & ~p[2] & f[2];
    count_nxt = count;
    if (do_step) count_nxt = fwd ? count + ONE : count - ONE;
    if (clr) count_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      s1         <= '0;
      s2         <= '0;
      f          <= '0;
      p          <= '0;
      for (int i = 0; i < 3; i++) fcnt[i] <= '0;
      count      <= '0;
      count_snap <= '0;
      index_pos  <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      changed    <= 1'b0;
      err        <= 1'b0;
      z_flag     <= 1'b0;
    end else begin
      s1 <= {Z, B, A};
      s2 <= s1;
      if (!run) begin
        // Absorb whatever level the inputs hold so nothing decodes on the way out of ARM.
        f <= s2;
        p <= s2;
        for (int i = 0; i < 3; i++) fcnt[i] <= '0;
      end else begin
        p <= f;
        for (int i = 0; i < 3; i++) begin
          if (s2[i] == f[i]) begin
            fcnt[i] <= '0;
          end else if (fcnt[i] == FLAST) begin
            f[i]    <= s2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FW'(1);
          end
        end
      end

      step  <= do_step;
      if (do_step) dir <= fwd;
      count <= count_nxt;

      if (clr)         err <= 1'b0;
      else if (do_err) err <= 1'b1;

      if (z_rise) index_pos <= count_nxt;
      if (clr)         z_flag <= 1'b0;
      else if (z_rise) z_flag <= 1'b1;

      if (snapshot) count_snap <= count;
      if (do_step)       changed <= 1'b1;
      else if (snapshot) changed <= 1'b0;
    end
  end

endmodule
